sound_peak_locator: RTL and testbench

SOUND_PEAK_LOCATOR -- requirements
Module: sound_peak_locator

---
 rtl/sound_pkg.sv | 15 +
 rtl/chan_mag.sv | 19 +
 rtl/sound_peak_locator.sv | 127 ++++++++++++
 tb/tb_sound_peak_locator.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/sound_pkg.sv
// Shared constants and FSM encoding for the sound peak locator.
package sound_pkg;
  localparam int NUM_CH   = 4;
  localparam int MIDSCALE = 512;
  localparam int SAMPLE_W = 11;
  localparam int MAG_W    = 10;
  localparam int CNT_W    = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_COMPARE,
    ST_REPORT
  } state_t;
endpackage

// File: rtl/chan_mag.sv
// Centre a 10-bit ADC code on midscale and return its absolute distance.
module chan_mag
  import sound_pkg::*;
(
  input  logic [SAMPLE_W-1:0] sample,
  output logic [MAG_W-1:0]    mag
);
  logic signed [SAMPLE_W-1:0] centered;
  logic                       unused_msb;

  // Bit 10 is always 0 from the ADC stage; only the 10-bit code is used.
  assign unused_msb = sample[SAMPLE_W-1];

  always_comb begin
    centered = signed'({1'b0, sample[MAG_W-1:0]}) - signed'(SAMPLE_W'(MIDSCALE));
    if (centered[SAMPLE_W-1]) mag = MAG_W'(-centered);
    else                      mag = MAG_W'(centered);
  end
endmodule

// File: rtl/sound_peak_locator.sv
// Tracks per-channel peak magnitude over a window of sample rounds and
// reports the loudest channel once per window.
//
// state   | meaning
// IDLE    | peaks and round counter held clear, waiting for enable
// ACCUM   | folding each round's magnitudes into the peak registers
// COMPARE | four-cycle scan for the largest peak, lowest index wins ties
// REPORT  | result presented with peak_valid for one cycle
module sound_peak_locator
  import sound_pkg::*;
#(
  parameter int WINDOW    = 256,
  parameter int THRESHOLD = 64
) (
  input  logic               clk_clk,
  input  logic               reset_n,
  input  logic [1:0]         select_ch,
  input  logic signed [10:0] SPI_CH0,
  input  logic signed [10:0] SPI_CH1,
  input  logic signed [10:0] SPI_CH2,
  input  logic signed [10:0] SPI_CH3,
  input  logic               enable,
  output logic               peak_valid,
  output logic [1:0]         peak_ch,
  output logic [9:0]         peak_mag,
  output logic               peak_active
);
  state_t                state;
  logic [1:0]            sel_q;
  logic [CNT_W-1:0]      round_cnt;
  logic [MAG_W-1:0]      peak [NUM_CH];
  logic [SAMPLE_W-1:0]   samples [NUM_CH];
  logic [MAG_W-1:0]      mags [NUM_CH];
  logic [1:0]            cmp_idx;
  logic [1:0]            best_ch;
  logic [MAG_W-1:0]      best_mag;
  logic                  strobe;
  logic                  win_done;
  logic [MAG_W-1:0]      cand;
  logic                  take;
  logic [1:0]            fin_ch;
  logic [MAG_W-1:0]      fin_mag;

  assign samples[0] = SPI_CH0;
  assign samples[1] = SPI_CH1;
  assign samples[2] = SPI_CH2;
  assign samples[3] = SPI_CH3;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_mag
    chan_mag u_mag (.sample(samples[g]), .mag(mags[g]));
  end

  // Channel 3 -> 0 wrap means the ADC stage has just refreshed all four.
  assign strobe   = (sel_q == 2'd3) && (select_ch == 2'd0);
  assign win_done = (round_cnt + CNT_W'(1)) == CNT_W'(WINDOW);

  always_comb begin
    cand    = peak[cmp_idx];
    take    = cand > best_mag;
    fin_ch  = take ? cmp_idx : best_ch;
    fin_mag = take ? cand : best_mag;
  end

  always_ff @(posedge clk_clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      sel_q       <= 2'd0;
      round_cnt   <= '0;
      for (int i = 0; i < NUM_CH; i++) peak[i] <= '0;
      cmp_idx     <= 2'd0;
      best_ch     <= 2'd0;
      best_mag    <= '0;
      peak_valid  <= 1'b0;
      peak_ch     <= 2'd0;
      peak_mag    <= '0;
      peak_active <= 1'b0;
    end else begin
      sel_q      <= select_ch;
      peak_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          round_cnt <= '0;
          for (int i = 0; i < NUM_CH; i++) peak[i] <= '0;
          if (enable) state <= ST_ACCUM;
        end
        ST_ACCUM: begin
          if (!enable) begin
            state <= ST_IDLE;
          end else if (strobe) begin
            for (int i = 0; i < NUM_CH; i++)
              if (mags[i] > peak[i]) peak[i] <= mags[i];
            round_cnt <= round_cnt + CNT_W'(1);
            if (win_done) begin
              state    <= ST_COMPARE;
              cmp_idx  <= 2'd0;
              best_ch  <= 2'd0;
              best_mag <= '0;
            end
          end
        end
        ST_COMPARE: begin
          if (!enable) begin
            state <= ST_IDLE;
          end else begin
            best_ch  <= fin_ch;
            best_mag <= fin_mag;
            cmp_idx  <= cmp_idx + 2'd1;
            // Last channel resolves straight into the output registers.
            if (cmp_idx == 2'd3) begin
              state       <= ST_REPORT;
              peak_valid  <= 1'b1;
              peak_ch     <= fin_ch;
              peak_mag    <= fin_mag;
              peak_active <= int'(fin_mag) >= THRESHOLD;
            end
          end
        end
        ST_REPORT: begin
          round_cnt <= '0;
          for (int i = 0; i < NUM_CH; i++) peak[i] <= '0;
          state <= enable ? ST_ACCUM : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sound_peak_locator.sv
// Directed bench for sound_peak_locator with WINDOW=4, THRESHOLD=64.
module tb_sound_peak_locator;
  localparam int WIN = 4;
  localparam int THR = 64;

  logic               clk_clk = 1'b0;
  logic               reset_n = 1'b0;
  logic [1:0]         select_ch = 2'd1;
  logic signed [10:0] spi0, spi1, spi2, spi3;
  logic               enable = 1'b0;
  logic               peak_valid;
  logic [1:0]         peak_ch;
  logic [9:0]         peak_mag;
  logic               peak_active;

  int n_cmp = 0;
  int n_err = 0;

  sound_peak_locator #(.WINDOW(WIN), .THRESHOLD(THR)) dut (
    .clk_clk(clk_clk), .reset_n(reset_n), .select_ch(select_ch),
    .SPI_CH0(spi0), .SPI_CH1(spi1), .SPI_CH2(spi2), .SPI_CH3(spi3),
    .enable(enable), .peak_valid(peak_valid), .peak_ch(peak_ch),
    .peak_mag(peak_mag), .peak_active(peak_active)
  );

  always #5 clk_clk = ~clk_clk;

  typedef struct {
    int a, b, c, d;
    int ech, emag, eact;
  } vec_t;
  vec_t vecs [8];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_data(input int a, input int b, input int c, input int d);
    spi0 = 11'(a); spi1 = 11'(b); spi2 = 11'(c); spi3 = 11'(d);
  endtask

  // Drive inputs just after the rising edge, sample outputs on the falling edge.
  task automatic step(input logic [1:0] sel, input logic en, output logic v);
    @(posedge clk_clk);
    #1;
    select_ch = sel;
    enable    = en;
    @(negedge clk_clk);
    v = peak_valid;
  endtask

  // Fast ADC cycling (one cycle per channel): strobes land at k = 3, 7, 11, 15,
  // so the report is expected at k = 15 + 5 = 20.
  task automatic run_window(input bit do_idle, input int swap_k,
                            input int sa, input int sb, input int sc, input int sd,
                            output int vcyc, output int npulse);
    logic v;
    vcyc = -1;
    npulse = 0;
    if (do_idle) for (int i = 0; i < 6; i++) step(2'd1, 1'b0, v);
    for (int k = 0; k < 25; k++) begin
      step(2'((k + 1) % 4), 1'b1, v);
      if (v) begin npulse++; vcyc = k; end
      if (k == swap_k) set_data(sa, sb, sc, sd);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   vc, np;
    logic v;
    logic [1:0] prev_sel, cur_sel;
    int   nstb, s4, s8, p0, p1, npul;
    int   ch0, mag0, ch1, mag1, hold_mag, hold_ch;

    vecs[0] = '{512, 700, 100, 512, 2, 412, 1};
    vecs[1] = '{512, 900, 512, 900, 1, 388, 1};
    vecs[2] = '{530, 530, 530, 530, 0,  18, 0};
    vecs[3] = '{  0, 512, 512, 512, 0, 512, 1};
    vecs[4] = '{1023, 512, 512, 1000, 0, 511, 1};
    vecs[5] = '{512, 512, 512, 576, 3,  64, 1};
    vecs[6] = '{512, 512, 449, 512, 2,  63, 0};
    vecs[7] = '{512, 512, 512, 512, 0,   0, 0};

    set_data(512, 512, 512, 512);
    #22;
    check("reset_valid",  int'(peak_valid),  0);
    check("reset_ch",     int'(peak_ch),     0);
    check("reset_mag",    int'(peak_mag),    0);
    check("reset_active", int'(peak_active), 0);
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      set_data(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d);
      run_window(1'b1, -1, 0, 0, 0, 0, vc, np);
      check($sformatf("vec%0d_latency", i), vc, 20);
      check($sformatf("vec%0d_pulses", i),  np, 1);
      check($sformatf("vec%0d_ch", i),      int'(peak_ch),     vecs[i].ech);
      check($sformatf("vec%0d_mag", i),     int'(peak_mag),    vecs[i].emag);
      check($sformatf("vec%0d_active", i),  int'(peak_active), vecs[i].eact);
    end

    // Single loud round (CH0=0) followed by three quiet rounds.
    set_data(0, 512, 512, 512);
    run_window(1'b1, 4, 512, 512, 512, 512, vc, np);
    check("single_latency", vc, 20);
    check("single_pulses",  np, 1);
    check("single_ch",      int'(peak_ch),  0);
    check("single_mag",     int'(peak_mag), 512);

    // ADC-stage timing: 13 cycles per channel, two back-to-back windows.
    set_data(512, 700, 100, 512);
    for (int i = 0; i < 6; i++) step(2'd1, 1'b0, v);
    prev_sel = 2'd1;
    nstb = 0; s4 = -1; s8 = -1; p0 = -1; p1 = -1; npul = 0;
    ch0 = -1; mag0 = -1; ch1 = -1; mag1 = -1; hold_mag = -1; hold_ch = -1;
    for (int c = 0; c < 431; c++) begin
      cur_sel = 2'((c / 13) % 4);
      step(cur_sel, 1'b1, v);
      if (prev_sel == 2'd3 && cur_sel == 2'd0 && c > 0) begin
        nstb++;
        if (nstb == 4) s4 = c;
        if (nstb == 8) s8 = c;
      end
      prev_sel = cur_sel;
      if (v) begin
        if (npul == 0) begin p0 = c; ch0 = int'(peak_ch); mag0 = int'(peak_mag); end
        if (npul == 1) begin p1 = c; ch1 = int'(peak_ch); mag1 = int'(peak_mag); end
        npul++;
      end
      if (nstb == 4 && c == s4 + 2) set_data(512, 900, 512, 900);
      if (c == 300) begin hold_mag = int'(peak_mag); hold_ch = int'(peak_ch); end
    end
    check("adc_pulses",     npul, 2);
    check("adc_latency1",   p0, s4 + 5);
    check("adc_latency2",   p1, s8 + 5);
    check("adc_ch1",        ch0, 2);
    check("adc_mag1",       mag0, 412);
    check("adc_hold_mag",   hold_mag, 412);
    check("adc_hold_ch",    hold_ch, 2);
    check("adc_ch2",        ch1, 1);
    check("adc_mag2",       mag1, 388);

    // Enable dropped after two rounds, then a fresh window.
    set_data(0, 512, 512, 512);
    for (int i = 0; i < 6; i++) step(2'd1, 1'b0, v);
    npul = 0;
    for (int k = 0; k < 21; k++) begin
      step(2'((k + 1) % 4), k < 9, v);
      if (v) npul++;
    end
    check("drop_no_report", npul, 0);
    set_data(512, 700, 100, 512);
    run_window(1'b0, -1, 0, 0, 0, 0, vc, np);
    check("drop_latency", vc, 20);
    check("drop_pulses",  np, 1);
    check("drop_ch",      int'(peak_ch),  2);
    check("drop_mag",     int'(peak_mag), 412);

    // Asynchronous reset between clock edges in the middle of a window.
    set_data(0, 512, 512, 512);
    for (int i = 0; i < 6; i++) step(2'd1, 1'b0, v);
    for (int k = 0; k < 9; k++) step(2'((k + 1) % 4), 1'b1, v);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_valid",  int'(peak_valid),  0);
    check("async_ch",     int'(peak_ch),     0);
    check("async_mag",    int'(peak_mag),    0);
    check("async_active", int'(peak_active), 0);
    @(posedge clk_clk);
    #1;
    reset_n   = 1'b1;
    select_ch = 2'd1;
    set_data(512, 900, 512, 900);
    run_window(1'b0, -1, 0, 0, 0, 0, vc, np);
    check("post_rst_latency", vc, 20);
    check("post_rst_pulses",  np, 1);
    check("post_rst_ch",      int'(peak_ch),  1);
    check("post_rst_mag",     int'(peak_mag), 388);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
